// File: rtl/pcs_transmit.sv
// rtl/pcs_transmit.sv - 1000BASE-X PCS transmit code-group state machine
// Turns GMII TXD/TX_EN/TX_ER into one RD- column 10-bit code group per clk.
module pcs_transmit #(
    parameter logic [2:0] XMIT_DATA = 3'b010
) (
    input  logic       clk,
    input  logic       mr_main_reset,
    input  logic [7:0] TXD,
    input  logic       TX_EN,
    input  logic       TX_ER,
    input  logic [2:0] xmit,
    output logic [9:0] tx_code_group,
    output logic       tx_even,
    output logic       transmitting,
    output logic       TX_CLK
);

    localparam logic [9:0] CG_K28_5 = 10'b0011111010;
    localparam logic [9:0] CG_D16_2 = 10'b0110110101;
    localparam logic [9:0] CG_S     = 10'b1101101000;
    localparam logic [9:0] CG_T     = 10'b1011101000;
    localparam logic [9:0] CG_R     = 10'b1110101000;
    localparam logic [9:0] CG_V     = 10'b0111101000;

    typedef enum logic [2:0] {
        IDLE_K,
        IDLE_D,
        SOP,
        DATA,
        EPD_T,
        EPD_R,
        EPD_R2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] cg_q, cg_d;
    logic       even_q;
    logic       transmitting_q, transmitting_d;
    logic       tx_clk_q;
    logic       mode_data;

    function automatic logic [9:0] enc_octet(input logic [7:0] octet);
        logic [9:0] cg;
        case (octet)
            8'h00:   cg = 10'b1001110100;  // D0.0
            8'h01:   cg = 10'b0111010100;  // D1.0
            8'h02:   cg = 10'b1011010100;  // D2.0
            8'h05:   cg = 10'b1010011011;  // D5.0
            8'h0A:   cg = 10'b0101011011;  // D10.0
            8'h15:   cg = 10'b1010101011;  // D21.0
            8'h2B:   cg = 10'b1101001001;  // D11.1
            8'h54:   cg = 10'b0010110101;  // D20.2
            8'h95:   cg = 10'b1010101101;  // D21.4
            8'hAA:   cg = 10'b0101011010;  // D10.5
            8'h50:   cg = 10'b0110110101;  // D16.2
            8'h55:   cg = 10'b1010100101;  // D21.2
            8'hD5:   cg = 10'b1010100110;  // D21.6
            default: cg = CG_V;
        endcase
        return cg;
    endfunction

    always_comb begin
        state_d   = state_q;
        cg_d      = CG_K28_5;
        mode_data = (xmit == XMIT_DATA);

        // IDLE_D always sits in an odd slot, so leaving it lands /S/ on an even slot.
        case (state_q)
            IDLE_K:  state_d = IDLE_D;
            IDLE_D:  state_d = (mode_data && TX_EN && !TX_ER) ? SOP : IDLE_K;
            SOP,
            DATA:    state_d = (mode_data && TX_EN) ? DATA : EPD_T;
            EPD_T:   state_d = EPD_R;
            EPD_R:   state_d = even_q ? EPD_R2 : IDLE_K;
            EPD_R2:  state_d = IDLE_K;
            default: state_d = IDLE_K;
        endcase

        case (state_d)
            IDLE_K:  cg_d = CG_K28_5;
            IDLE_D:  cg_d = CG_D16_2;
            SOP:     cg_d = CG_S;
            DATA:    cg_d = TX_ER ? CG_V : enc_octet(TXD);
            EPD_T:   cg_d = CG_T;
            EPD_R,
            EPD_R2:  cg_d = CG_R;
            default: cg_d = CG_K28_5;
        endcase

        transmitting_d = state_d inside {SOP, DATA, EPD_T, EPD_R, EPD_R2};
    end

    always_ff @(posedge clk) begin
        if (mr_main_reset) begin
            state_q        <= IDLE_K;
            cg_q           <= CG_K28_5;
            even_q         <= 1'b1;
            transmitting_q <= 1'b0;
            tx_clk_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cg_q           <= cg_d;
            even_q         <= ~even_q;
            transmitting_q <= transmitting_d;
            tx_clk_q       <= ~tx_clk_q;
        end
    end

    assign tx_code_group = cg_q;
    assign tx_even       = even_q;
    assign transmitting  = transmitting_q;
    assign TX_CLK        = tx_clk_q;

endmodule

// File: tb/tb_pcs_transmit.sv
// tb/tb_pcs_transmit.sv - self-checking bench for pcs_transmit
// Stimulus traces are compared against a frame-level model of the code-group stream.
module tb_pcs_transmit;

    localparam logic [2:0] XD   = 3'b010;
    localparam logic [9:0] K285 = 10'b0011111010;
    localparam logic [9:0] D162 = 10'b0110110101;
    localparam logic [9:0] CG_S = 10'b1101101000;
    localparam logic [9:0] CG_T = 10'b1011101000;
    localparam logic [9:0] CG_R = 10'b1110101000;
    localparam logic [9:0] CG_V = 10'b0111101000;
    localparam int MAXN = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       tx_er = 1'b0;
    logic [7:0] txd = 8'h00;
    logic [2:0] xm = XD;
    logic [9:0] cg;
    logic       ev, trn, txclk;

    always #5 clk = ~clk;

    pcs_transmit #(.XMIT_DATA(3'b010)) dut (
        .clk(clk), .mr_main_reset(rst), .TXD(txd), .TX_EN(tx_en), .TX_ER(tx_er),
        .xmit(xm), .tx_code_group(cg), .tx_even(ev), .transmitting(trn), .TX_CLK(txclk)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic       s_en [MAXN];
    logic       s_er [MAXN];
    logic [7:0] s_d  [MAXN];
    logic [2:0] s_x  [MAXN];
    logic [9:0] o_cg [MAXN];
    logic       o_ev [MAXN];
    logic       o_tr [MAXN];
    logic       o_ck [MAXN];
    logic [9:0] e_cg [MAXN+4];
    logic       e_tr [MAXN+4];

    logic [7:0] tbl_oct [13] = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h0A, 8'h15, 8'h2B,
                                 8'h54, 8'h95, 8'hAA, 8'h50, 8'h55, 8'hD5};
    logic [9:0] tbl_cg [13] = '{10'b1001110100, 10'b0111010100, 10'b1011010100,
                                10'b1010011011, 10'b0101011011, 10'b1010101011,
                                10'b1101001001, 10'b0010110101, 10'b1010101101,
                                10'b0101011010, 10'b0110110101, 10'b1010100101,
                                10'b1010100110};

    function automatic logic [9:0] ref_enc(input logic [7:0] o);
        for (int i = 0; i < 13; i++) if (tbl_oct[i] == o) return tbl_cg[i];
        return CG_V;
    endfunction

    // {valid, octet}: what a receiver recovers from a data code group
    function automatic logic [8:0] ref_dec(input logic [9:0] c);
        for (int i = 0; i < 13; i++) if (tbl_cg[i] == c) return {1'b1, tbl_oct[i]};
        return 9'h000;
    endfunction

    // Slot k (k-th cycle after reset release) is even when k is odd: the reset slot itself is even.
    function automatic void build_expected(input int n);
        int k = 0;
        int j;
        while (k < n) begin
            if ((k % 2 == 1) && s_en[k] && !s_er[k] && s_x[k] == XD) begin
                e_cg[k] = CG_S; e_tr[k] = 1'b1;
                j = k + 1;
                while (j < n && s_en[j] && s_x[j] == XD) begin
                    e_cg[j] = s_er[j] ? CG_V : ref_enc(s_d[j]);
                    e_tr[j] = 1'b1;
                    j++;
                end
                e_cg[j] = CG_T; e_tr[j] = 1'b1;
                e_cg[j+1] = CG_R; e_tr[j+1] = 1'b1;
                k = j + 2;
                if (k % 2 == 0) begin
                    e_cg[k] = CG_R; e_tr[k] = 1'b1; k++;
                end
                e_cg[k] = K285; e_tr[k] = 1'b0; k++;
            end else begin
                e_cg[k] = (k % 2 == 1) ? K285 : D162;
                e_tr[k] = 1'b0;
                k++;
            end
        end
    endfunction

    task automatic step(input logic r, input logic e, input logic er, input logic [7:0] d,
                        input logic [2:0] x);
        rst = r; tx_en = e; tx_er = er; txd = d; xm = x;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, XD);
    endtask

    task automatic clear_stim(input int n);
        for (int i = 0; i < n; i++) begin
            s_en[i] = 1'b0; s_er[i] = 1'b0; s_d[i] = 8'($urandom); s_x[i] = XD;
        end
    endtask

    task automatic run_trace(input int n);
        do_reset();
        for (int i = 0; i < n; i++) begin
            step(1'b0, s_en[i], s_er[i], s_d[i], s_x[i]);
            o_cg[i] = cg; o_ev[i] = ev; o_tr[i] = trn; o_ck[i] = txclk;
        end
        build_expected(n);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (cg !== K285) begin n_fail++; $display("FAIL reset_cg got %b want %b", cg, K285); end
        n_checks++;
        if (ev !== 1'b1) begin n_fail++; $display("FAIL reset_even got %b want 1", ev); end
        n_checks++;
        if (trn !== 1'b0) begin n_fail++; $display("FAIL reset_transmitting got %b want 0", trn); end
        n_checks++;
        if (txclk !== 1'b0) begin n_fail++; $display("FAIL reset_tx_clk got %b want 0", txclk); end
    endtask

    task automatic test_idle();
        clear_stim(12);
        run_trace(12);
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (o_cg[i] !== e_cg[i] || o_tr[i] !== e_tr[i] || o_ev[i] !== (i % 2 == 1) ||
                o_ck[i] !== (i % 2 == 0)) begin
                n_fail++;
                $display("FAIL idle slot %0d: got cg=%b tr=%b ev=%b clk=%b want cg=%b tr=%b ev=%b clk=%b",
                         i, o_cg[i], o_tr[i], o_ev[i], o_ck[i], e_cg[i], e_tr[i], i % 2 == 1, i % 2 == 0);
            end
        end
    endtask

    task automatic test_frame_even();
        logic [9:0] lit [9];
        logic [7:0] fr [5];
        logic [8:0] dec;
        lit = '{CG_S, 10'b1010100101, 10'b1010100110, 10'b1001110100, 10'b1101001001,
                CG_T, CG_R, CG_R, K285};
        fr = '{8'h55, 8'h55, 8'hD5, 8'h00, 8'h2B};
        clear_stim(18);
        for (int i = 0; i < 5; i++) begin s_en[5+i] = 1'b1; s_d[5+i] = fr[i]; end
        run_trace(18);
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (o_cg[5+i] !== lit[i]) begin
                n_fail++;
                $display("FAIL frame_even_literal slot %0d: got %b want %b", 5 + i, o_cg[5+i], lit[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            dec = ref_dec(o_cg[6+i]);
            n_checks++;
            if (dec !== {1'b1, fr[i+1]}) begin
                n_fail++;
                $display("FAIL frame_even_loopback octet %0d: got %h want %h", i, dec, {1'b1, fr[i+1]});
            end
        end
        for (int i = 0; i < 18; i++) begin
            n_checks++;
            if (o_cg[i] !== e_cg[i] || o_tr[i] !== e_tr[i] || o_ev[i] !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL frame_even slot %0d: got cg=%b tr=%b ev=%b want cg=%b tr=%b ev=%b",
                         i, o_cg[i], o_tr[i], o_ev[i], e_cg[i], e_tr[i], i % 2 == 1);
            end
        end
    endtask

    task automatic test_frame_odd();
        logic [7:0] fr [5];
        fr = '{8'h55, 8'h55, 8'hD5, 8'h00, 8'h2B};
        clear_stim(16);
        for (int i = 0; i < 5; i++) begin s_en[4+i] = 1'b1; s_d[4+i] = fr[i]; end
        run_trace(16);
        n_checks++;
        if (o_cg[4] !== D162 || o_cg[5] !== CG_S) begin
            n_fail++;
            $display("FAIL frame_odd_start got %b,%b want %b,%b", o_cg[4], o_cg[5], D162, CG_S);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (o_cg[i] !== e_cg[i] || o_tr[i] !== e_tr[i] || o_ev[i] !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL frame_odd slot %0d: got cg=%b tr=%b ev=%b want cg=%b tr=%b ev=%b",
                         i, o_cg[i], o_tr[i], o_ev[i], e_cg[i], e_tr[i], i % 2 == 1);
            end
        end
    endtask

    task automatic test_errors();
        clear_stim(18);
        for (int i = 3; i <= 10; i++) begin s_en[i] = 1'b1; s_d[i] = tbl_oct[i]; end
        s_er[5] = 1'b1;
        s_d[7]  = 8'h37;
        run_trace(18);
        n_checks++;
        if (o_cg[5] !== CG_V || o_cg[7] !== CG_V || o_cg[11] !== CG_T) begin
            n_fail++;
            $display("FAIL errors_literal got %b,%b,%b want %b,%b,%b",
                     o_cg[5], o_cg[7], o_cg[11], CG_V, CG_V, CG_T);
        end
        for (int i = 0; i < 18; i++) begin
            n_checks++;
            if (o_cg[i] !== e_cg[i] || o_tr[i] !== e_tr[i]) begin
                n_fail++;
                $display("FAIL errors slot %0d: got cg=%b tr=%b want cg=%b tr=%b",
                         i, o_cg[i], o_tr[i], e_cg[i], e_tr[i]);
            end
        end
    endtask

    task automatic test_xmit_change();
        clear_stim(30);
        for (int i = 3; i <= 12; i++) s_en[i] = 1'b1;
        for (int i = 7; i < 30; i++) s_x[i] = 3'b001;
        for (int i = 16; i <= 18; i++) s_en[i] = 1'b1;
        s_en[23] = 1'b1; s_en[24] = 1'b1;
        run_trace(30);
        n_checks++;
        if (o_cg[7] !== CG_T || o_cg[8] !== CG_R) begin
            n_fail++;
            $display("FAIL xmit_change_end got %b,%b want %b,%b", o_cg[7], o_cg[8], CG_T, CG_R);
        end
        for (int i = 0; i < 30; i++) begin
            n_checks++;
            if (o_cg[i] !== e_cg[i] || o_tr[i] !== e_tr[i]) begin
                n_fail++;
                $display("FAIL xmit_change slot %0d: got cg=%b tr=%b want cg=%b tr=%b",
                         i, o_cg[i], o_tr[i], e_cg[i], e_tr[i]);
            end
        end
    endtask

    task automatic test_start_rules();
        int n_sop = 0;
        clear_stim(24);
        for (int i = 3; i <= 8; i++) s_en[i] = 1'b1;
        s_er[3] = 1'b1;
        s_en[10] = 1'b1; s_en[11] = 1'b1;
        s_en[16] = 1'b1;
        run_trace(24);
        for (int i = 0; i < 24; i++) if (o_cg[i] == CG_S) n_sop++;
        n_checks++;
        if (n_sop != 1 || o_cg[3] !== K285) begin
            n_fail++;
            $display("FAIL start_rules sop_count=%0d slot3=%b want 1 and %b", n_sop, o_cg[3], K285);
        end
        for (int i = 0; i < 24; i++) begin
            n_checks++;
            if (o_cg[i] !== e_cg[i] || o_tr[i] !== e_tr[i]) begin
                n_fail++;
                $display("FAIL start_rules slot %0d: got cg=%b tr=%b want cg=%b tr=%b",
                         i, o_cg[i], o_tr[i], e_cg[i], e_tr[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h55, XD);
        step(1'b0, 1'b1, 1'b0, 8'h55, XD);
        step(1'b0, 1'b1, 1'b0, 8'hD5, XD);
        step(1'b0, 1'b1, 1'b0, 8'h00, XD);
        n_checks++;
        if (trn !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre got tr=%b want 1", trn); end
        step(1'b1, 1'b1, 1'b0, 8'h2B, XD);
        n_checks++;
        if (cg !== K285 || ev !== 1'b1 || trn !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got cg=%b ev=%b tr=%b want cg=%b ev=1 tr=0", cg, ev, trn, K285);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, XD);
        n_checks++;
        if (cg !== D162 || ev !== 1'b0 || trn !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after got cg=%b ev=%b tr=%b want cg=%b ev=0 tr=0", cg, ev, trn, D162);
        end
    endtask

    task automatic test_random();
        int i = 0;
        int len;
        clear_stim(400);
        while (i < 400) begin
            i += $urandom_range(2, 8);
            len = $urandom_range(1, 12);
            for (int j = 0; j < len && i < 400; j++) begin
                s_en[i] = 1'b1;
                s_d[i]  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : tbl_oct[$urandom_range(0, 12)];
                s_er[i] = ($urandom_range(0, 15) == 0);
                i++;
            end
        end
        for (int j = 0; j < 400; j++) if ($urandom_range(0, 29) == 0) s_x[j] = 3'b001;
        run_trace(400);
        for (int j = 0; j < 400; j++) begin
            n_checks++;
            if (o_cg[j] !== e_cg[j] || o_tr[j] !== e_tr[j] || o_ev[j] !== (j % 2 == 1)) begin
                n_fail++;
                $display("FAIL random slot %0d: got cg=%b tr=%b ev=%b want cg=%b tr=%b ev=%b",
                         j, o_cg[j], o_tr[j], o_ev[j], e_cg[j], e_tr[j], j % 2 == 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame_even();
        test_frame_odd();
        test_errors();
        test_xmit_change();
        test_start_rules();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
